dt_tree_walker: RTL



---
 rtl/dt_pkg.sv | 33 +++
 rtl/dt_feature_rf.sv | 30 +++
 rtl/dt_tree_walker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared types and constants for the decision-tree walker: node field offsets,
// FSM state encoding, Q32.32 feature type and default sizing.
package dt_pkg;

  localparam int DEF_NUM_FEATURES = 8;
  localparam int DEF_FIDX_W       = 3;
  localparam int DEF_NODE_AW      = 8;
  localparam int DEF_CLASS_W      = 4;
  localparam int DEF_MAX_DEPTH    = 32;

  // Node word, LSB upward: thr | right | left | fidx | is_leaf
  localparam int THR_W     = 64;
  localparam int THR_LSB   = 0;
  localparam int RIGHT_LSB = THR_LSB + THR_W;

  function automatic int left_lsb(input int node_aw);
    return RIGHT_LSB + node_aw;
  endfunction

  function automatic int fidx_lsb(input int node_aw);
    return RIGHT_LSB + 2 * node_aw;
  endfunction

  typedef logic signed [63:0] q32_32_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_DONE   = 2'd3
  } dt_state_t;

endpackage

// File: rtl/dt_feature_rf.sv
// Feature register file: one write port, one combinational read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module dt_feature_rf
  import dt_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int FIDX_W       = DEF_FIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [FIDX_W-1:0] widx,
  input  q32_32_t           wdata,
  input  logic [FIDX_W-1:0] ridx,
  output q32_32_t           rdata
);

  q32_32_t regs [NUM_FEATURES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FEATURES; i++) regs[i] <= '0;
    end else if (we && (int'(widx) < NUM_FEATURES)) begin
      regs[widx] <= wdata;
    end
  end

  assign rdata = (int'(ridx) < NUM_FEATURES) ? regs[ridx] : '0;

endmodule

// File: rtl/dt_tree_walker.sv
// Walks a decision tree held in external sync-read node memory and returns the
// leaf class. Optional macro DT_DEPTH_OUT_EN adds the result_depth output.
module dt_tree_walker
  import dt_pkg::*;
#(
  parameter  int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter  int FIDX_W       = DEF_FIDX_W,
  parameter  int NODE_AW      = DEF_NODE_AW,
  parameter  int CLASS_W      = DEF_CLASS_W,
  parameter  int MAX_DEPTH    = DEF_MAX_DEPTH,
  localparam int NODE_W       = 1 + FIDX_W + 2 * NODE_AW + THR_W,
  localparam int DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               feat_we,
  input  logic [FIDX_W-1:0]  feat_idx,
  input  logic [63:0]        feat_data,
  input  logic               start,
  output logic               busy,
  output logic               node_rd_en,
  output logic [NODE_AW-1:0] node_addr,
  input  logic [NODE_W-1:0]  node_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_err,
  output dt_state_t          dbg_state
`ifdef DT_DEPTH_OUT_EN
  ,
  output logic [DEPTH_W-1:0] result_depth
`endif
);

  localparam int LEFT_LSB = left_lsb(NODE_AW);
  localparam int FIDX_LSB = fidx_lsb(NODE_AW);

  dt_state_t          state, state_nx;
  logic [NODE_AW-1:0] addr;
  logic [DEPTH_W-1:0] depth;
  logic [CLASS_W-1:0] cls_q;
  logic               err_q;

  logic               is_leaf;
  logic [FIDX_W-1:0]  n_fidx;
  logic [NODE_AW-1:0] n_left, n_right;
  q32_32_t            n_thr, feat_val;
  logic               fidx_bad, depth_max, go_left, dec_stop;

  assign is_leaf   = node_data[NODE_W-1];
  assign n_fidx    = node_data[FIDX_LSB +: FIDX_W];
  assign n_left    = node_data[LEFT_LSB +: NODE_AW];
  assign n_right   = node_data[RIGHT_LSB +: NODE_AW];
  assign n_thr     = node_data[THR_LSB +: THR_W];
  assign fidx_bad  = int'(n_fidx) >= NUM_FEATURES;
  assign depth_max = depth == DEPTH_W'(MAX_DEPTH - 1);
  assign go_left   = feat_val <= n_thr;
  assign dec_stop  = is_leaf || fidx_bad || depth_max;

  // Features are only writable while no walk or result is pending.
  dt_feature_rf #(
    .NUM_FEATURES (NUM_FEATURES),
    .FIDX_W       (FIDX_W)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (feat_we && (state == S_IDLE)),
    .widx  (feat_idx),
    .wdata (feat_data),
    .ridx  (n_fidx),
    .rdata (feat_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = dec_stop ? S_DONE : S_FETCH;
      S_DONE:   if (result_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Result handshake: result_valid stays high with class/err frozen until the
  // cycle result_ready is also high; the transfer happens in that cycle.
  always_comb begin
    busy         = (state == S_FETCH) || (state == S_DECODE);
    node_rd_en   = (state == S_FETCH);
    result_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      depth <= '0;
      cls_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= '0;
            depth <= '0;
          end
        end
        S_DECODE: begin
          if (is_leaf) begin
            cls_q <= n_thr[CLASS_W-1:0];
            err_q <= 1'b0;
          end else if (fidx_bad || depth_max) begin
            cls_q <= '0;
            err_q <= 1'b1;
          end else begin
            addr  <= go_left ? n_left : n_right;
            depth <= depth + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign node_addr    = addr;
  assign result_class = cls_q;
  assign result_err   = err_q;
  assign dbg_state    = state;

`ifdef DT_DEPTH_OUT_EN
  assign result_depth = depth;
`endif

endmodule
